// File: rtl/aer_sender.sv
// AER link transmitter: event FIFO, ACK synchroniser and 4-phase REQ/ACK handshake FSM.
// Optional ACK timeout/abort is enabled by defining AER_ACK_TIMEOUT_EN.
module aer_sender #(
  parameter int ADDR_W      = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ev_valid,
  input  logic [ADDR_W-1:0]             ev_addr,
  output logic                          ev_ready,
  output logic [ADDR_W-1:0]             aer_addr,
  output logic                          aer_req,
  input  logic                          aer_ack,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [7:0]                    drop_cnt,
  output logic                          timeout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, SETUP, REQ_HI, REQ_LO} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [ADDR_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   tmo_hit;

  // Raw aer_ack is only ever seen by the first synchroniser flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], aer_ack};
    end
  end

  assign ack_s    = ack_sync[SYNC_STAGES-1];
  assign empty    = (fifo_count == '0);
  assign full     = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign pop      = (state == IDLE) && !empty && !ack_s;
  assign ev_ready = !full || pop;
  assign push     = ev_valid && ev_ready;
  assign busy     = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ev_addr;
    end
  end

  // A push and pop in the same cycle leave the occupancy unchanged, even when full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      drop_cnt   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (ev_valid && !ev_ready && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

`ifdef AER_ACK_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  logic [TMO_W-1:0] tmo_cnt;

  assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

  // Counter restarts on entry to each waiting state; a hit aborts the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= tmo_hit && (((state == REQ_HI) && !ack_s) ||
                             ((state == REQ_LO) && ack_s));
      if ((state == SETUP) || ((state == REQ_HI) && ack_s)) begin
        tmo_cnt <= '0;
      end else if ((state == REQ_HI) || (state == REQ_LO)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      end
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign timeout = (TIMEOUT_CYC < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      aer_addr <= '0;
      aer_req  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            aer_addr <= mem[rd_ptr];
            state    <= SETUP;
          end
        end
        SETUP: begin
          aer_req <= 1'b1;
          state   <= REQ_HI;
        end
        REQ_HI: begin
          if (ack_s) begin
            aer_req <= 1'b0;
            state   <= REQ_LO;
          end else if (tmo_hit) begin
            aer_req <= 1'b0;
            state   <= IDLE;
          end
        end
        REQ_LO: begin
          if (!ack_s || tmo_hit) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aer_sender.sv
// Self-checking bench for aer_sender: receiver model, bus monitor and an address scoreboard.
// The abort scenario is exercised only when AER_ACK_TIMEOUT_EN is defined.
module tb_aer_sender;

  localparam int ADDR_W      = 8;
  localparam int FIFO_DEPTH  = 4;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int ACK_DLY     = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              ev_valid = 1'b0;
  logic [ADDR_W-1:0] ev_addr = '0;
  logic              ev_ready;
  logic [ADDR_W-1:0] aer_addr;
  logic              aer_req;
  logic              aer_ack;
  logic              busy;
  logic [2:0]        fifo_count;
  logic [7:0]        drop_cnt;
  logic              timeout;

  logic rx_en = 1'b0;
  logic rx_ack = 1'b0;
  int   rx_cnt = 0;
  logic ack_override = 1'b0;
  logic ack_force = 1'b0;

  int check_cnt = 0;
  int pass_cnt = 0;

  logic [7:0] exp_q[$];
  logic [7:0] obs_mem [64];
  int         obs_wr = 0;
  int         obs_rd = 0;
  int         stab_err = 0;
  int         tmo_seen = 0;
  logic       req_q = 1'b0;
  logic [7:0] rise_addr = '0;

  assign aer_ack = ack_override ? ack_force : rx_ack;

  aer_sender #(
    .ADDR_W      (ADDR_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ev_valid   (ev_valid),
    .ev_addr    (ev_addr),
    .ev_ready   (ev_ready),
    .aer_addr   (aer_addr),
    .aer_req    (aer_req),
    .aer_ack    (aer_ack),
    .busy       (busy),
    .fifo_count (fifo_count),
    .drop_cnt   (drop_cnt),
    .timeout    (timeout)
  );

  always #5 clk = ~clk;

  // Receiver: follows aer_req with aer_ack after ACK_DLY cycles in both directions.
  always @(negedge clk) begin
    if (!rx_en) begin
      rx_ack <= 1'b0;
      rx_cnt <= 0;
    end else if (aer_req != rx_ack) begin
      if (rx_cnt == ACK_DLY - 1) begin
        rx_ack <= aer_req;
        rx_cnt <= 0;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end else begin
      rx_cnt <= 0;
    end
  end

  // Bus monitor: records the address at each REQ rise and flags address changes while REQ is high.
  always @(negedge clk) begin
    if (aer_req && !req_q) begin
      obs_mem[obs_wr % 64] <= aer_addr;
      obs_wr    <= obs_wr + 1;
      rise_addr <= aer_addr;
    end else if (aer_req && (aer_addr != rise_addr)) begin
      stab_err <= stab_err + 1;
    end
    if (timeout) begin
      tmo_seen <= tmo_seen + 1;
    end
    req_q <= aer_req;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expected);
    check_cnt++;
    if (got === expected) begin
      pass_cnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expected);
    end
  endtask

  task automatic doReset();
    ev_valid = 1'b0;
    rst_n    = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_wr;
  endtask

  task automatic applyStimulus(input logic [7:0] addr, input logic exp_ready);
    @(negedge clk);
    ev_valid = 1'b1;
    ev_addr  = addr;
    checkOutput($sformatf("ev_ready_%02h", addr), ev_ready, exp_ready);
    if (exp_ready) begin
      exp_q.push_back(addr);
    end
  endtask

  task automatic endStimulus();
    @(negedge clk);
    ev_valid = 1'b0;
  endtask

  task automatic expectNext(input string tag, input int budget);
    int n = 0;
    logic [7:0] e;
    while ((obs_rd == obs_wr) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, (obs_rd != obs_wr), 1);
    if (obs_rd != obs_wr) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      checkOutput(tag, obs_mem[obs_rd % 64], e);
      obs_rd++;
    end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    int n = 0;
    while ((busy || aer_ack) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    checkOutput(tag, busy, 0);
  endtask

  initial begin
    int base;
    int n;

    $display("[TB] single event handshake");
    doReset();
    checkOutput("rst_aer_req", aer_req, 0);
    checkOutput("rst_aer_addr", aer_addr, 0);
    checkOutput("rst_fifo_count", fifo_count, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_timeout", timeout, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_ev_ready", ev_ready, 1);
    rx_en = 1'b1;
    base  = obs_wr;
    applyStimulus(8'h5A, 1'b1);
    endStimulus();
    checkOutput("t1_count_after_write", fifo_count, 1);
    checkOutput("t1_req_after_write", aer_req, 0);
    @(negedge clk);
    checkOutput("t1_addr_setup", aer_addr, 8'h5A);
    checkOutput("t1_req_setup", aer_req, 0);
    @(negedge clk);
    checkOutput("t1_req_rise", aer_req, 1);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (!aer_ack && (n < 40));
    checkOutput("t1_ack_seen", aer_ack, 1);
    repeat (2) @(negedge clk);
    checkOutput("t1_req_hold", aer_req, 1);
    @(negedge clk);
    checkOutput("t1_req_fall", aer_req, 0);
    expectNext("t1_addr", 40);
    waitIdle("t1_busy", 40);
    checkOutput("t1_count_final", fifo_count, 0);
    checkOutput("t1_hs_count", obs_wr - base, 1);

    $display("[TB] burst into full FIFO");
    doReset();
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(8'(i), (i <= 5));
    end
    endStimulus();
    checkOutput("t2_drop_cnt", drop_cnt, 1);
    checkOutput("t2_count_full", fifo_count, 4);
    checkOutput("t2_ready_full", ev_ready, 0);
    checkOutput("t2_req_inflight", aer_req, 1);
    checkOutput("t2_addr_inflight", aer_addr, 8'h01);
    rx_en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      expectNext($sformatf("t2_ev%0d", i), 60);
    end
    waitIdle("t2_busy", 60);
    checkOutput("t2_drop_final", drop_cnt, 1);

    $display("[TB] write while full with simultaneous pop");
    rx_en        = 1'b0;
    ack_override = 1'b1;
    ack_force    = 1'b0;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(8'h11 + 8'(i), 1'b1);
    end
    @(negedge clk);
    ev_valid  = 1'b0;
    ack_force = 1'b1;
    checkOutput("t3_count_full", fifo_count, 4);
    repeat (3) @(negedge clk);
    checkOutput("t3_req_fall", aer_req, 0);
    ack_force = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("t3_ready_reqlo", ev_ready, 0);
    applyStimulus(8'h16, 1'b1);
    endStimulus();
    checkOutput("t3_count_same", fifo_count, 4);
    checkOutput("t3_req_setup", aer_req, 0);
    @(negedge clk);
    checkOutput("t3_req_rise", aer_req, 1);
    checkOutput("t3_addr", aer_addr, 8'h12);
    ack_override = 1'b0;
    rx_en        = 1'b1;
    for (int i = 0; i < 6; i++) begin
      expectNext($sformatf("t3_ev%0d", i), 60);
    end
    waitIdle("t3_busy", 60);

    $display("[TB] ACK high at reset release");
    rx_en        = 1'b0;
    ack_override = 1'b1;
    ack_force    = 1'b1;
    doReset();
    applyStimulus(8'h77, 1'b1);
    endStimulus();
    repeat (8) @(negedge clk);
    checkOutput("t4_req_held", aer_req, 0);
    checkOutput("t4_count_held", fifo_count, 1);
    checkOutput("t4_busy_held", busy, 1);
    checkOutput("t4_no_early_tx", obs_wr - obs_rd, 0);
    ack_override = 1'b0;
    rx_en        = 1'b1;
    expectNext("t4_ev", 40);
    waitIdle("t4_busy", 60);

    $display("[TB] reset during REQ_HI");
    rx_en = 1'b0;
    doReset();
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h34, 1'b1);
    endStimulus();
    @(negedge clk);
    checkOutput("t5_req_before", aer_req, 1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("t5_req_async", aer_req, 0);
    checkOutput("t5_count_async", fifo_count, 0);
    checkOutput("t5_busy_async", busy, 0);
    checkOutput("t5_addr_async", aer_addr, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    obs_rd = obs_wr;
    rx_en  = 1'b1;
    applyStimulus(8'h35, 1'b1);
    endStimulus();
    expectNext("t5_after_reset", 40);
    waitIdle("t5_busy", 60);
    checkOutput("t5_count_final", fifo_count, 0);

`ifdef AER_ACK_TIMEOUT_EN
    $display("[TB] ACK timeout abort");
    rx_en = 1'b0;
    doReset();
    base = tmo_seen;
    applyStimulus(8'h61, 1'b1);
    applyStimulus(8'h62, 1'b1);
    endStimulus();
    @(negedge clk);
    checkOutput("t6_req_rise", aer_req, 1);
    repeat (15) @(negedge clk);
    checkOutput("t6_req_last", aer_req, 1);
    checkOutput("t6_tmo_early", timeout, 0);
    @(negedge clk);
    checkOutput("t6_req_abort", aer_req, 0);
    checkOutput("t6_tmo_pulse", timeout, 1);
    rx_en = 1'b1;
    @(negedge clk);
    checkOutput("t6_tmo_end", timeout, 0);
    expectNext("t6_lost", 10);
    expectNext("t6_next", 60);
    waitIdle("t6_busy", 60);
    checkOutput("t6_tmo_count", tmo_seen - base, 1);
`else
    checkOutput("timeout_tied", tmo_seen, 0);
`endif

    checkOutput("addr_stable", stab_err, 0);
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
